// File: rtl/decode.sv
`default_nettype none
// ============================================================================
// Module   : decode
// Purpose  : RV32I instruction-decode stage. Splits the fetched instruction
//            into fields, builds the sign-extended immediate, reads the 32x32
//            register file (written from writeback, with same-cycle bypass)
//            and captures everything in the ID/EX pipeline register.
// Ports    : clk, reset (async, active-low)
//            instruction_in, pc_in, valid_in   - from fetch
//            stall, flush                      - ID/EX register control
//            wb_en, wb_rd, wb_data             - register-file write port
//            pc_out, rs1_data, rs2_data, imm_out, rs1_out, rs2_out, rd_out,
//            opcode_out, funct3_out, funct7_out, reg_write_out,
//            illegal_out, valid_out            - ID/EX register outputs
// Revision : 1.0 - initial release
// ============================================================================
module decode (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction_in,
    input  logic [31:0] pc_in,
    input  logic        valid_in,
    input  logic        stall,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic [31:0] pc_out,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    output logic [31:0] imm_out,
    output logic [4:0]  rs1_out,
    output logic [4:0]  rs2_out,
    output logic [4:0]  rd_out,
    output logic [6:0]  opcode_out,
    output logic [2:0]  funct3_out,
    output logic [6:0]  funct7_out,
    output logic        reg_write_out,
    output logic        illegal_out,
    output logic        valid_out
);

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_MISC   = 7'b0001111;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_OP     = 7'b0110011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

    // Field extraction
    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [6:0]  w_funct7;

    assign w_opcode = instruction_in[6:0];
    assign w_rd     = instruction_in[11:7];
    assign w_funct3 = instruction_in[14:12];
    assign w_rs1    = instruction_in[19:15];
    assign w_rs2    = instruction_in[24:20];
    assign w_funct7 = instruction_in[31:25];

    // Immediate generation and opcode classification
    logic [31:0] w_imm;
    logic        w_legal;
    logic        w_writes_rd;

    always_comb begin
        w_imm       = '0;
        w_legal     = 1'b1;
        w_writes_rd = 1'b0;
        case (w_opcode)
            c_OP_LOAD, c_OP_IMM, c_OP_JALR, c_OP_SYSTEM: begin
                w_imm       = {{20{instruction_in[31]}}, instruction_in[31:20]};
                w_writes_rd = 1'b1;
            end
            c_OP_MISC: begin
                w_imm = {{20{instruction_in[31]}}, instruction_in[31:20]};
            end
            c_OP_STORE: begin
                w_imm = {{20{instruction_in[31]}}, instruction_in[31:25],
                         instruction_in[11:7]};
            end
            c_OP_BRANCH: begin
                w_imm = {{19{instruction_in[31]}}, instruction_in[31],
                         instruction_in[7], instruction_in[30:25],
                         instruction_in[11:8], 1'b0};
            end
            c_OP_LUI, c_OP_AUIPC: begin
                w_imm       = {instruction_in[31:12], 12'b0};
                w_writes_rd = 1'b1;
            end
            c_OP_JAL: begin
                w_imm       = {{11{instruction_in[31]}}, instruction_in[31],
                               instruction_in[19:12], instruction_in[20],
                               instruction_in[30:21], 1'b0};
                w_writes_rd = 1'b1;
            end
            c_OP_OP: begin
                w_writes_rd = 1'b1;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    logic w_reg_write;
    logic w_illegal;

    assign w_reg_write = valid_in & w_writes_rd & (w_rd != 5'd0);
    assign w_illegal   = valid_in & ~w_legal;

    // Register file. x0 is never written, so it always reads its reset value 0.
    logic [31:0] r_regs [32];
    logic        w_wb_hit;

    assign w_wb_hit = wb_en && (wb_rd != 5'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_hit) begin
            r_regs[wb_rd] <= wb_data;
        end
    end

    // Same-cycle writeback bypass so a read never sees stale data
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;

    assign w_rs1_val = (w_wb_hit && (wb_rd == w_rs1)) ? wb_data : r_regs[w_rs1];
    assign w_rs2_val = (w_wb_hit && (wb_rd == w_rs2)) ? wb_data : r_regs[w_rs2];

    // ID/EX pipeline register: flush beats stall beats capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_out        <= '0;
            rs1_data      <= '0;
            rs2_data      <= '0;
            imm_out       <= '0;
            rs1_out       <= '0;
            rs2_out       <= '0;
            rd_out        <= '0;
            opcode_out    <= '0;
            funct3_out    <= '0;
            funct7_out    <= '0;
            reg_write_out <= 1'b0;
            illegal_out   <= 1'b0;
            valid_out     <= 1'b0;
        end else if (flush) begin
            pc_out        <= '0;
            rs1_data      <= '0;
            rs2_data      <= '0;
            imm_out       <= '0;
            rs1_out       <= '0;
            rs2_out       <= '0;
            rd_out        <= '0;
            opcode_out    <= '0;
            funct3_out    <= '0;
            funct7_out    <= '0;
            reg_write_out <= 1'b0;
            illegal_out   <= 1'b0;
            valid_out     <= 1'b0;
        end else if (!stall) begin
            pc_out        <= pc_in;
            rs1_data      <= w_rs1_val;
            rs2_data      <= w_rs2_val;
            imm_out       <= w_imm;
            rs1_out       <= w_rs1;
            rs2_out       <= w_rs2;
            rd_out        <= w_rd;
            opcode_out    <= w_opcode;
            funct3_out    <= w_funct3;
            funct7_out    <= w_funct7;
            reg_write_out <= w_reg_write;
            illegal_out   <= w_illegal;
            valid_out     <= valid_in;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode
// Purpose  : Self-checking bench for decode. A behavioural reference model
//            (arithmetic immediates, array register file) predicts the ID/EX
//            outputs; directed scenarios plus randomized traffic are compared
//            against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode;

    logic        clk;
    logic        reset;
    logic [31:0] instruction_in;
    logic [31:0] pc_in;
    logic        valid_in;
    logic        stall;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] pc_out;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm_out;
    logic [4:0]  rs1_out;
    logic [4:0]  rs2_out;
    logic [4:0]  rd_out;
    logic [6:0]  opcode_out;
    logic [2:0]  funct3_out;
    logic [6:0]  funct7_out;
    logic        reg_write_out;
    logic        illegal_out;
    logic        valid_out;

    decode dut (
        .clk            (clk),
        .reset          (reset),
        .instruction_in (instruction_in),
        .pc_in          (pc_in),
        .valid_in       (valid_in),
        .stall          (stall),
        .flush          (flush),
        .wb_en          (wb_en),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .pc_out         (pc_out),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .imm_out        (imm_out),
        .rs1_out        (rs1_out),
        .rs2_out        (rs2_out),
        .rd_out         (rd_out),
        .opcode_out     (opcode_out),
        .funct3_out     (funct3_out),
        .funct7_out     (funct7_out),
        .reg_write_out  (reg_write_out),
        .illegal_out    (illegal_out),
        .valid_out      (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        rw;
        logic        ill;
        logic        v;
    } outs_t;

    outs_t dut_o;
    assign dut_o = {pc_out, rs1_data, rs2_data, imm_out, rs1_out, rs2_out, rd_out,
                    opcode_out, funct3_out, funct7_out, reg_write_out, illegal_out,
                    valid_out};

    // Reference model state
    outs_t       exp_o;
    logic [31:0] mregs [32];
    int          n_pass;
    int          n_total;

    logic [6:0] legal_ops  [11] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
                                    7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};
    logic [6:0] writer_ops [8]  = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13,
                                    7'h33, 7'h73};

    function automatic bit in_legal(logic [6:0] op);
        foreach (legal_ops[k]) if (legal_ops[k] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit in_writer(logic [6:0] op);
        foreach (writer_ops[k]) if (writer_ops[k] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Immediate value computed arithmetically from the encoding rules
    function automatic logic [31:0] ref_imm(logic [31:0] ins);
        int v;
        v = 0;
        case (ins[6:0])
            7'h03, 7'h13, 7'h67, 7'h73, 7'h0F:
                v = $signed(ins) >>> 20;
            7'h23:
                v = ($signed(ins) >>> 25) * 32 + int'(ins[11:7]);
            7'h63:
                v = int'(ins[31]) * (-4096) + int'(ins[7]) * 2048
                  + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
            7'h37, 7'h17:
                v = int'(ins & 32'hFFFF_F000);
            7'h6F:
                v = int'(ins[31]) * (-1048576) + int'(ins[19:12]) * 4096
                  + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
            default:
                v = 0;
        endcase
        return 32'(v);
    endfunction

    function automatic logic [31:0] ref_read(logic [4:0] idx);
        if (wb_en && wb_rd != 0 && wb_rd == idx) return wb_data;
        return mregs[idx];
    endfunction

    // Advance the model by one clock edge using the current inputs
    task automatic predict();
        outs_t n;
        if (flush) begin
            n = '0;
        end else if (stall) begin
            n = exp_o;
        end else begin
            n.pc  = pc_in;
            n.rs1 = instruction_in[19:15];
            n.rs2 = instruction_in[24:20];
            n.rd  = instruction_in[11:7];
            n.op  = instruction_in[6:0];
            n.f3  = instruction_in[14:12];
            n.f7  = instruction_in[31:25];
            n.r1  = ref_read(n.rs1);
            n.r2  = ref_read(n.rs2);
            n.imm = ref_imm(instruction_in);
            n.rw  = valid_in && in_writer(n.op) && n.rd != 0;
            n.ill = valid_in && !in_legal(n.op);
            n.v   = valid_in;
        end
        if (wb_en && wb_rd != 0) mregs[wb_rd] = wb_data;
        exp_o = n;
    endtask

    task automatic model_reset();
        foreach (mregs[k]) mregs[k] = '0;
        exp_o = '0;
    endtask

    task automatic cycle();
        predict();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        #1;
        n_total++;
        if (dut_o !== '0) $display("FAIL reset_immediate got=%h exp=0", dut_o);
        else n_pass++;
        @(posedge clk);
        #1;
        n_total++;
        if (dut_o !== '0) $display("FAIL reset_held got=%h exp=0", dut_o);
        else n_pass++;
        reset = 1'b1;
    endtask

    task automatic test_addi();
        instruction_in = 32'h0050_0093;
        pc_in          = 32'h0000_0004;
        valid_in       = 1'b1;
        cycle();
        n_total++;
        if ({opcode_out, rd_out, rs1_out, imm_out, reg_write_out, valid_out, illegal_out}
            !== {7'h13, 5'd1, 5'd0, 32'd5, 1'b1, 1'b1, 1'b0})
            $display("FAIL addi_fields got op=%h rd=%0d rs1=%0d imm=%h rw=%b v=%b ill=%b exp op=13 rd=1 rs1=0 imm=5 rw=1 v=1 ill=0",
                     opcode_out, rd_out, rs1_out, imm_out, reg_write_out, valid_out, illegal_out);
        else n_pass++;
        n_total++;
        if (dut_o !== exp_o) $display("FAIL addi_model got=%h exp=%h", dut_o, exp_o);
        else n_pass++;
    endtask

    task automatic test_bypass();
        instruction_in = 32'h0021_01B3;
        wb_en   = 1'b1;
        wb_rd   = 5'd2;
        wb_data = 32'hDEAD_BEEF;
        cycle();
        n_total++;
        if ({rs1_data, rs2_data, imm_out} !== {32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0})
            $display("FAIL bypass got r1=%h r2=%h imm=%h exp r1=deadbeef r2=deadbeef imm=0",
                     rs1_data, rs2_data, imm_out);
        else n_pass++;
        wb_en = 1'b0;
        cycle();
        n_total++;
        if ({rs1_data, rs2_data} !== {32'hDEAD_BEEF, 32'hDEAD_BEEF})
            $display("FAIL regfile_read got r1=%h r2=%h exp deadbeef", rs1_data, rs2_data);
        else n_pass++;
        n_total++;
        if (dut_o !== exp_o) $display("FAIL bypass_model got=%h exp=%h", dut_o, exp_o);
        else n_pass++;
    endtask

    task automatic test_branch_x0();
        instruction_in = 32'hFE00_0EE3;
        pc_in          = 32'h0000_0010;
        cycle();
        n_total++;
        if ({imm_out, reg_write_out, pc_out} !== {32'hFFFF_FFFC, 1'b0, 32'h10})
            $display("FAIL branch got imm=%h rw=%b pc=%h exp imm=fffffffc rw=0 pc=10",
                     imm_out, reg_write_out, pc_out);
        else n_pass++;
        instruction_in = 32'h0050_0093;
        wb_en   = 1'b1;
        wb_rd   = 5'd0;
        wb_data = 32'h1234;
        cycle();
        wb_en = 1'b0;
        cycle();
        n_total++;
        if (rs1_data !== 32'h0) $display("FAIL x0_write got=%h exp=0", rs1_data);
        else n_pass++;
    endtask

    task automatic test_stall_flush();
        outs_t held;
        instruction_in = 32'h0021_01B3;
        pc_in          = 32'h0000_0020;
        valid_in       = 1'b1;
        cycle();
        held  = exp_o;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instruction_in = $urandom;
            pc_in          = $urandom;
            wb_en          = 1'b1;
            wb_rd          = 5'd2;
            wb_data        = 32'h1111_1111 * (i + 1);
            cycle();
            n_total++;
            if (dut_o !== exp_o || dut_o !== held)
                $display("FAIL stall_hold cyc=%0d got=%h exp=%h", i, dut_o, held);
            else n_pass++;
        end
        n_total++;
        if (rs1_data !== 32'hDEAD_BEEF) $display("FAIL stall_frozen_rs1 got=%h exp=deadbeef", rs1_data);
        else n_pass++;
        wb_en = 1'b0;
        flush = 1'b1;
        cycle();
        n_total++;
        if (dut_o !== '0 || valid_out !== 1'b0 || reg_write_out !== 1'b0)
            $display("FAIL stall_flush got=%h exp=0", dut_o);
        else n_pass++;
        stall = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_illegal();
        instruction_in = 32'hFFFF_FFFF;
        valid_in       = 1'b1;
        cycle();
        n_total++;
        if ({illegal_out, reg_write_out, imm_out} !== {1'b1, 1'b0, 32'h0})
            $display("FAIL illegal got ill=%b rw=%b imm=%h exp ill=1 rw=0 imm=0",
                     illegal_out, reg_write_out, imm_out);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [6:0] ops [13] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37,
                                 7'h63, 7'h67, 7'h6F, 7'h73, 7'h7F, 7'h00};
        int errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            logic [31:0] r;
            r              = $urandom;
            instruction_in = {r[31:7], ops[$urandom_range(0, 12)]};
            pc_in          = $urandom;
            valid_in       = ($urandom_range(0, 7) != 0);
            stall          = ($urandom_range(0, 7) == 0);
            flush          = ($urandom_range(0, 15) == 0);
            wb_en          = $urandom_range(0, 1) == 1;
            wb_rd          = 5'($urandom_range(0, 31));
            wb_data        = $urandom;
            cycle();
            n_total++;
            if (dut_o !== exp_o) begin
                errs++;
                if (errs <= 5)
                    $display("FAIL random cyc=%0d instr=%h got=%h exp=%h",
                             i, instruction_in, dut_o, exp_o);
            end else n_pass++;
        end
        stall = 1'b0;
        flush = 1'b0;
        wb_en = 1'b0;
    endtask

    task automatic test_async_reset();
        wb_en          = 1'b1;
        wb_rd          = 5'd5;
        wb_data        = 32'hA5A5_A5A5;
        instruction_in = 32'h0000_0013;
        valid_in       = 1'b1;
        cycle();
        wb_en          = 1'b0;
        instruction_in = 32'h0002_8333;   // add x6,x5,x0
        cycle();
        n_total++;
        if (rs1_data !== 32'hA5A5_A5A5) $display("FAIL x5_written got=%h exp=a5a5a5a5", rs1_data);
        else n_pass++;
        wb_en   = 1'b1;
        wb_rd   = 5'd7;
        wb_data = 32'h7777_7777;
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        n_total++;
        if (dut_o !== '0) $display("FAIL async_reset got=%h exp=0", dut_o);
        else n_pass++;
        @(posedge clk);
        #1;
        reset = 1'b1;
        wb_en = 1'b0;
        cycle();
        n_total++;
        if (rs1_data !== 32'h0 || dut_o !== exp_o)
            $display("FAIL reset_clears_regs got r1=%h exp=0 (full got=%h exp=%h)",
                     rs1_data, dut_o, exp_o);
        else n_pass++;
    endtask

    initial begin
        n_pass         = 0;
        n_total        = 0;
        reset          = 1'b0;
        instruction_in = '0;
        pc_in          = '0;
        valid_in       = 1'b0;
        stall          = 1'b0;
        flush          = 1'b0;
        wb_en          = 1'b0;
        wb_rd          = '0;
        wb_data        = '0;
        test_reset();
        test_addi();
        test_bypass();
        test_branch_x0();
        test_stall_flush();
        test_illegal();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
